// File: rtl/tdc_pair_stamper.sv
// Timestamps synchronised start/stop edges against a free-running coarse counter
// and emits each completed measurement as a strict start/stop pair of dval strobes.
module tdc_pair_stamper #(
    parameter int               CNT_W    = 37,
    parameter logic [CNT_W-1:0] CNT_INIT = '0,
    parameter int               TIMEOUT  = 5000,
    parameter int               GAP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start_in,
    input  logic             stop_in,
    output logic [CNT_W-1:0] mlt,
    output logic             dval,
    output logic             busy,
    output logic             pair_err,
    output logic [7:0]       pair_cnt,
    output logic [7:0]       drop_cnt
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_EMIT1, S_GAP, S_EMIT2} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] ts, t_start, t_stop;
    logic [2:0]       sync_start, sync_stop;
    logic             start_edge, stop_edge;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       gap_cnt;
    logic             cap_start, cap_stop, timeout_hit, emitting;
    logic [8:0]       drop_sum;

    // Identical 2-FF synchroniser + edge register on both channels so their latency cancels.
    assign start_edge = sync_start[1] & ~sync_start[2];
    assign stop_edge  = sync_stop[1]  & ~sync_stop[2];
    assign emitting   = (state == S_EMIT1) || (state == S_GAP) || (state == S_EMIT2);
    assign busy       = (state != S_IDLE);
    assign pair_err   = timeout_hit;
    assign drop_sum   = {1'b0, drop_cnt} + 9'(start_edge) + 9'(stop_edge);

    always_comb begin
        state_n     = state;
        cap_start   = 1'b0;
        cap_stop    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && start_edge) begin
                    cap_start = 1'b1;
                    state_n   = S_ARMED;
                end
            end
            S_ARMED: begin
                // Stop beats a simultaneous start; any edge defers the timeout.
                if (!enable) begin
                    state_n = S_IDLE;
                end else if (stop_edge) begin
                    cap_stop = 1'b1;
                    state_n  = S_EMIT1;
                end else if (start_edge) begin
                    cap_start = 1'b1;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_n     = S_IDLE;
                end
            end
            S_EMIT1: state_n = S_GAP;
            S_GAP:   if (gap_cnt == 4'(GAP - 1)) state_n = S_EMIT2;
            S_EMIT2: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ts         <= CNT_INIT;
            sync_start <= '0;
            sync_stop  <= '0;
            t_start    <= '0;
            t_stop     <= '0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            mlt        <= '0;
            dval       <= 1'b0;
            pair_cnt   <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_n;
            ts         <= ts + CNT_W'(1);
            sync_start <= {sync_start[1:0], start_in};
            sync_stop  <= {sync_stop[1:0], stop_in};

            if (cap_start)  t_start <= ts;
            if (cap_stop)   t_stop  <= ts;

            if (cap_start)              to_cnt <= '0;
            else if (state == S_ARMED)  to_cnt <= to_cnt + TO_W'(1);

            if (state == S_EMIT1)       gap_cnt <= '0;
            else if (state == S_GAP)    gap_cnt <= gap_cnt + 4'd1;

            // Strobe and word registered together; mlt holds between strobes.
            dval <= (state_n == S_EMIT1) || (state_n == S_EMIT2);
            if (state_n == S_EMIT1)      mlt <= t_start;
            else if (state_n == S_EMIT2) mlt <= t_stop;

            if (state == S_EMIT2) pair_cnt <= pair_cnt + 8'd1;
            if (emitting)         drop_cnt <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule

// File: tb/tb_tdc_pair_stamper.sv
// Randomised pair/timeout/drop/reset scenarios on two stamper configurations,
// checked against stamps predicted from drive cycles and the coarse-counter rules.
module tb_tdc_pair_stamper;

    localparam int               W      = 37;
    localparam logic [W-1:0]     INIT_A = 37'h1F_FFFF_FFD8;  // 2^37 - 40
    localparam logic [W-1:0]     INIT_B = '0;
    localparam int               GAP_A  = 1;
    localparam int               GAP_B  = 4;
    localparam int               TO_A   = 200;
    localparam int               TO_B   = 50;

    logic clk = 1'b0, rst = 1'b0, enable = 1'b1, start_in = 1'b0, stop_in = 1'b0;
    logic [W-1:0] a_mlt, b_mlt;
    logic         a_dval, b_dval, a_busy, b_busy, a_err, b_err;
    logic [7:0]   a_pc, b_pc, a_dc, b_dc;

    typedef struct {int c; logic [W-1:0] v;} stamp_t;
    stamp_t qa[$], qb[$];
    int     ea[$], eb[$];
    int     cyc;
    int     tests = 0, fails = 0;

    always #5 clk = ~clk;

    tdc_pair_stamper #(.CNT_W(W), .CNT_INIT(INIT_A), .TIMEOUT(TO_A), .GAP(GAP_A)) u_a (
        .clk(clk), .rst(rst), .enable(enable), .start_in(start_in), .stop_in(stop_in),
        .mlt(a_mlt), .dval(a_dval), .busy(a_busy), .pair_err(a_err),
        .pair_cnt(a_pc), .drop_cnt(a_dc));

    tdc_pair_stamper #(.CNT_W(W), .CNT_INIT(INIT_B), .TIMEOUT(TO_B), .GAP(GAP_B)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .start_in(start_in), .stop_in(stop_in),
        .mlt(b_mlt), .dval(b_dval), .busy(b_busy), .pair_err(b_err),
        .pair_cnt(b_pc), .drop_cnt(b_dc));

    // Cycle index since reset release; coarse counter reads INIT + cyc.
    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (a_dval) qa.push_back('{cyc, a_mlt});
            if (b_dval) qb.push_back('{cyc, b_mlt});
            if (a_err)  ea.push_back(cyc);
            if (b_err)  eb.push_back(cyc);
        end
    end

    // Reference: a pin driven after edge p is stamped with INIT + p + 2.
    function automatic logic [W-1:0] stamp(logic [W-1:0] init, int p);
        return init + W'(p + 2);
    endfunction

    function automatic logic on(int s, int k);
        return (s >= 0) && (k >= s) && (k < s + 3);
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; enable = 1'b1; start_in = 1'b0; stop_in = 1'b0;
        tick(3);
        rst = 1'b1;
        qa.delete(); qb.delete(); ea.delete(); eb.delete();
    endtask

    // Up to two 3-cycle pulses per channel at offsets from the current cycle (-1 = none).
    task automatic drive(input int s1, input int s2, input int p1, input int p2,
                         input int n, output int base);
        base = cyc;
        for (int k = 0; k < n; k++) begin
            start_in = on(s1, k) || on(s2, k);
            stop_in  = on(p1, k) || on(p2, k);
            tick(1);
        end
        start_in = 1'b0; stop_in = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests++; if (a_mlt !== '0)   begin fails++; $display("FAIL reset_mlt: got %0h want 0", a_mlt); end
        tests++; if (a_dval !== 1'b0) begin fails++; $display("FAIL reset_dval: got %b want 0", a_dval); end
        tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        tests++; if (a_err !== 1'b0)  begin fails++; $display("FAIL reset_err: got %b want 0", a_err); end
        tests++; if (a_pc !== 8'd0)   begin fails++; $display("FAIL reset_pair_cnt: got %0d want 0", a_pc); end
        tests++; if (b_dc !== 8'd0)   begin fails++; $display("FAIL reset_drop_cnt: got %0d want 0", b_dc); end
    endtask

    task automatic test_wrap;
        int base;
        do_reset();
        drive(20, -1, 70, -1, 80, base);
        tests++; if (qa.size() !== 2) begin fails++; $display("FAIL wrap_count: got %0d want 2", qa.size()); end
        if (qa.size() == 2) begin
            tests++; if (qa[0].v !== stamp(INIT_A, base + 20))
                begin fails++; $display("FAIL wrap_start: got %0h want %0h", qa[0].v, stamp(INIT_A, base + 20)); end
            tests++; if (qa[1].v !== stamp(INIT_A, base + 70))
                begin fails++; $display("FAIL wrap_stop: got %0h want %0h", qa[1].v, stamp(INIT_A, base + 70)); end
            tests++; if (!(qa[1].v < qa[0].v))
                begin fails++; $display("FAIL wrap_order: got %0h,%0h want stop<start", qa[0].v, qa[1].v); end
            tests++; if (W'(qa[1].v - qa[0].v) !== W'(50))
                begin fails++; $display("FAIL wrap_diff: got %0d want 50", W'(qa[1].v - qa[0].v)); end
            tests++; if (qa[0].c !== base + 73)
                begin fails++; $display("FAIL wrap_latency: got %0d want %0d", qa[0].c, base + 73); end
        end
        tests++; if (a_pc !== 8'd1) begin fails++; $display("FAIL wrap_pair_cnt: got %0d want 1", a_pc); end
    endtask

    task automatic test_basic;
        int base, sep;
        int exp_pc;
        do_reset();
        exp_pc = 0;
        for (int i = 0; i < 6; i++) begin
            sep = (i == 0) ? 100 : int'($urandom_range(1, 150));
            qa.delete(); ea.delete();
            drive(2, -1, 2 + sep, -1, sep + 12, base);
            exp_pc++;
            tests++; if (qa.size() !== 2) begin fails++; $display("FAIL basic_count[%0d]: got %0d want 2", i, qa.size()); end
            if (qa.size() == 2) begin
                tests++; if (qa[0].v !== stamp(INIT_A, base + 2))
                    begin fails++; $display("FAIL basic_start[%0d]: got %0h want %0h", i, qa[0].v, stamp(INIT_A, base + 2)); end
                tests++; if (W'(qa[1].v - qa[0].v) !== W'(sep))
                    begin fails++; $display("FAIL basic_diff[%0d]: got %0d want %0d", i, W'(qa[1].v - qa[0].v), sep); end
                tests++; if (qa[1].c - qa[0].c !== GAP_A + 1)
                    begin fails++; $display("FAIL basic_spacing[%0d]: got %0d want %0d", i, qa[1].c - qa[0].c, GAP_A + 1); end
            end
            tests++; if (a_pc !== 8'(exp_pc)) begin fails++; $display("FAIL basic_pair_cnt[%0d]: got %0d want %0d", i, a_pc, exp_pc); end
            tests++; if (ea.size() !== 0) begin fails++; $display("FAIL basic_err[%0d]: got %0d pulses want 0", i, ea.size()); end
        end
    endtask

    task automatic test_timeout;
        int b0, b1, b2;
        do_reset();
        drive(5, -1, -1, -1, 10, b0);
        tests++; if (b_busy !== 1'b1) begin fails++; $display("FAIL timeout_busy_armed: got %b want 1", b_busy); end
        drive(-1, -1, -1, -1, 55, b1);
        tests++; if (eb.size() !== 1) begin fails++; $display("FAIL timeout_err_count: got %0d want 1", eb.size()); end
        if (eb.size() == 1) begin
            tests++; if (eb[0] !== b0 + 5 + 2 + TO_B)
                begin fails++; $display("FAIL timeout_err_cycle: got %0d want %0d", eb[0], b0 + 7 + TO_B); end
        end
        tests++; if (qb.size() !== 0) begin fails++; $display("FAIL timeout_dval: got %0d strobes want 0", qb.size()); end
        tests++; if (b_busy !== 1'b0) begin fails++; $display("FAIL timeout_busy_idle: got %b want 0", b_busy); end
        drive(2, -1, 12, -1, 30, b2);
        tests++; if (qb.size() !== 2) begin fails++; $display("FAIL timeout_next_count: got %0d want 2", qb.size()); end
        if (qb.size() == 2) begin
            tests++; if (W'(qb[1].v - qb[0].v) !== W'(10))
                begin fails++; $display("FAIL timeout_next_diff: got %0d want 10", W'(qb[1].v - qb[0].v)); end
        end
        tests++; if (b_pc !== 8'd1) begin fails++; $display("FAIL timeout_pair_cnt: got %0d want 1", b_pc); end
    endtask

    task automatic test_simultaneous;
        int base;
        do_reset();
        drive(2, -1, 2, 32, 50, base);
        tests++; if (qa.size() !== 2) begin fails++; $display("FAIL simul_count: got %0d want 2", qa.size()); end
        if (qa.size() == 2) begin
            tests++; if (qa[0].v !== stamp(INIT_A, base + 2))
                begin fails++; $display("FAIL simul_start: got %0h want %0h", qa[0].v, stamp(INIT_A, base + 2)); end
            tests++; if (W'(qa[1].v - qa[0].v) !== W'(30))
                begin fails++; $display("FAIL simul_diff: got %0d want 30", W'(qa[1].v - qa[0].v)); end
        end
        qa.delete();
        drive(2, 12, 42, -1, 60, base);
        tests++; if (qa.size() !== 2) begin fails++; $display("FAIL restart_count: got %0d want 2", qa.size()); end
        if (qa.size() == 2) begin
            tests++; if (qa[0].v !== stamp(INIT_A, base + 12))
                begin fails++; $display("FAIL restart_start: got %0h want %0h", qa[0].v, stamp(INIT_A, base + 12)); end
            tests++; if (W'(qa[1].v - qa[0].v) !== W'(30))
                begin fails++; $display("FAIL restart_diff: got %0d want 30", W'(qa[1].v - qa[0].v)); end
        end
        tests++; if (a_pc !== 8'd2) begin fails++; $display("FAIL simul_pair_cnt: got %0d want 2", a_pc); end
    endtask

    task automatic test_gap_drop;
        int base, sep;
        do_reset();
        drive(2, 26, 22, 26, 40, base);
        tests++; if (qb.size() !== 2) begin fails++; $display("FAIL drop_count: got %0d want 2", qb.size()); end
        if (qb.size() == 2) begin
            tests++; if (W'(qb[1].v - qb[0].v) !== W'(20))
                begin fails++; $display("FAIL drop_diff: got %0d want 20", W'(qb[1].v - qb[0].v)); end
            tests++; if (qb[1].c - qb[0].c !== GAP_B + 1)
                begin fails++; $display("FAIL drop_spacing: got %0d want %0d", qb[1].c - qb[0].c, GAP_B + 1); end
        end
        tests++; if (b_dc !== 8'd2) begin fails++; $display("FAIL drop_cnt: got %0d want 2", b_dc); end
        qb.delete();
        sep = int'($urandom_range(1, 40));
        drive(2, -1, 2 + sep, -1, sep + 20, base);
        tests++; if (qb.size() !== 2) begin fails++; $display("FAIL drop_next_count: got %0d want 2", qb.size()); end
        if (qb.size() == 2) begin
            tests++; if (qb[0].v !== stamp(INIT_B, base + 2))
                begin fails++; $display("FAIL drop_next_start: got %0h want %0h", qb[0].v, stamp(INIT_B, base + 2)); end
            tests++; if (W'(qb[1].v - qb[0].v) !== W'(sep))
                begin fails++; $display("FAIL drop_next_diff: got %0d want %0d", W'(qb[1].v - qb[0].v), sep); end
        end
        tests++; if (b_pc !== 8'd2) begin fails++; $display("FAIL drop_pair_cnt: got %0d want 2", b_pc); end
    endtask

    task automatic test_rst_gap;
        int base;
        do_reset();
        drive(0, -1, 25, -1, 30, base);
        tests++; if (qb.size() !== 1) begin fails++; $display("FAIL rstgap_first: got %0d strobes want 1", qb.size()); end
        rst = 1'b0;
        #1;
        tests++; if (b_dval !== 1'b0) begin fails++; $display("FAIL rstgap_dval: got %b want 0", b_dval); end
        tests++; if (b_busy !== 1'b0) begin fails++; $display("FAIL rstgap_busy: got %b want 0", b_busy); end
        tests++; if (b_mlt !== '0)    begin fails++; $display("FAIL rstgap_mlt: got %0h want 0", b_mlt); end
        tick(2);
        rst = 1'b1;
        drive(-1, -1, -1, -1, 15, base);
        tests++; if (qb.size() !== 1) begin fails++; $display("FAIL rstgap_no_stop: got %0d strobes want 1", qb.size()); end
        tests++; if (b_pc !== 8'd0)   begin fails++; $display("FAIL rstgap_pair_cnt: got %0d want 0", b_pc); end
        qb.delete();
        drive(2, -1, 27, -1, 45, base);
        tests++; if (qb.size() !== 2) begin fails++; $display("FAIL rstgap_next_count: got %0d want 2", qb.size()); end
        if (qb.size() == 2) begin
            tests++; if (W'(qb[1].v - qb[0].v) !== W'(25))
                begin fails++; $display("FAIL rstgap_next_diff: got %0d want 25", W'(qb[1].v - qb[0].v)); end
        end
        tests++; if (b_pc !== 8'd1) begin fails++; $display("FAIL rstgap_next_pair_cnt: got %0d want 1", b_pc); end
    endtask

    task automatic test_back_to_back;
        int base;
        do_reset();
        // Second start lands on the first IDLE cycle; second pair is minimum separation.
        drive(2, 14, 10, 15, 40, base);
        tests++; if (qa.size() !== 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", qa.size()); end
        if (qa.size() == 4) begin
            tests++; if (W'(qa[1].v - qa[0].v) !== W'(8))
                begin fails++; $display("FAIL b2b_diff1: got %0d want 8", W'(qa[1].v - qa[0].v)); end
            tests++; if (qa[2].v !== stamp(INIT_A, base + 14))
                begin fails++; $display("FAIL b2b_start2: got %0h want %0h", qa[2].v, stamp(INIT_A, base + 14)); end
            tests++; if (W'(qa[3].v - qa[2].v) !== W'(1))
                begin fails++; $display("FAIL b2b_diff2: got %0d want 1", W'(qa[3].v - qa[2].v)); end
            tests++; if (qa[2].c !== base + 18)
                begin fails++; $display("FAIL b2b_latency2: got %0d want %0d", qa[2].c, base + 18); end
        end
        tests++; if (a_pc !== 8'd2) begin fails++; $display("FAIL b2b_pair_cnt: got %0d want 2", a_pc); end
    endtask

    task automatic test_enable;
        int base;
        do_reset();
        enable = 1'b0;
        drive(2, -1, 10, -1, 25, base);
        tests++; if (qa.size() !== 0) begin fails++; $display("FAIL enable_dval: got %0d strobes want 0", qa.size()); end
        tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL enable_busy: got %b want 0", a_busy); end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_basic();
        test_timeout();
        test_simultaneous();
        test_gap_drop();
        test_rst_gap();
        test_back_to_back();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
